alu_mc_unit: RTL and testbench

ALU_MC_UNIT -- requirements
Module: alu_mc_unit

---
 rtl/alu_mc_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_mc_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_unit.sv
// ---------------------------------------------------------------------------
// alu_mc_unit -- multi-cycle integer ALU with a valid/ready handshake.
//
// Single-cycle ops (add/sub/and/or/xor/slt/sltu and illegal encodings) finish
// one cycle after accept. Shifts step one bit position per cycle. The optional
// shift-add multiplier takes XLEN iterations.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> MUL state, multiplier datapath and mul decode are present
//   undefined -> mul encodings decode as illegal (latency 1)
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : request handshake (in_ready only while IDLE)
//   aluop, funct3, funct7b5, funct7b0, op5 : instruction fields to decode
//   src_a, src_b        : XLEN-bit operands
//   flush               : synchronous abort of any operation in flight
//   out_valid/out_ready : result handshake
//   result, zero, illegal, alu_ctrl : registered result and status
// ---------------------------------------------------------------------------
module alu_mc_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      alu_ctrl
);

    // One extra counter bit so the multiplier can count XLEN iterations.
    localparam int CW = SHW + 1;

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_AND  = 4'b0010;
    localparam logic [3:0] CTRL_OR   = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLT  = 4'b0101;
    localparam logic [3:0] CTRL_SLTU = 4'b0110;
    localparam logic [3:0] CTRL_SLL  = 4'b0111;
    localparam logic [3:0] CTRL_SRL  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] CTRL_MUL  = 4'b1010;
`endif
    localparam logic [3:0] CTRL_ILL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef ALU_MUL_EN
        MUL   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] mul_acc;
`endif

    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_step;
    logic            dec_is_shift;
    logic [SHW-1:0]  shamt;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign alu_ctrl  = ctrl_q;
    assign shamt     = src_b[SHW-1:0];

    // Decode the instruction fields into the internal operation code.
    always_comb begin
        dec_ctrl = CTRL_ILL;
        case (aluop)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                if (op5 && funct7b0) begin
                    // M-extension encodings; only plain mul is supported.
`ifdef ALU_MUL_EN
                    dec_ctrl = (funct3 == 3'b000) ? CTRL_MUL : CTRL_ILL;
`else
                    dec_ctrl = CTRL_ILL;
`endif
                end else begin
                    case (funct3)
                        3'b000:  dec_ctrl = (op5 && funct7b5) ? CTRL_SUB : CTRL_ADD;
                        3'b001:  dec_ctrl = CTRL_SLL;
                        3'b010:  dec_ctrl = CTRL_SLT;
                        3'b011:  dec_ctrl = CTRL_SLTU;
                        3'b100:  dec_ctrl = CTRL_XOR;
                        3'b101:  dec_ctrl = funct7b5 ? CTRL_SRA : CTRL_SRL;
                        3'b110:  dec_ctrl = CTRL_OR;
                        default: dec_ctrl = CTRL_AND;
                    endcase
                end
            end
            default: dec_ctrl = CTRL_ILL;
        endcase
    end

    // Single-cycle datapath; shifts, mul and illegal produce zero here.
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            CTRL_ADD:  alu_res = src_a + src_b;
            CTRL_SUB:  alu_res = src_a - src_b;
            CTRL_AND:  alu_res = src_a & src_b;
            CTRL_OR:   alu_res = src_a | src_b;
            CTRL_XOR:  alu_res = src_a ^ src_b;
            CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:   alu_res = '0;
        endcase
    end

    assign dec_is_shift = (dec_ctrl == CTRL_SLL) || (dec_ctrl == CTRL_SRL) ||
                          (dec_ctrl == CTRL_SRA);

    // One bit position of the shift in flight.
    always_comb begin
        shift_step = '0;
        case (ctrl_q)
            CTRL_SLL: shift_step = {result_q[XLEN-2:0], 1'b0};
            CTRL_SRL: shift_step = {1'b0, result_q[XLEN-1:1]};
            default:  shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    assign mul_acc = mplier_q[0] ? (result_q + mcand_q) : result_q;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= CTRL_ADD;
            cnt_q     <= '0;
`ifdef ALU_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
`ifdef ALU_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`endif
        end
    end

    // Next-state and datapath control. Flush overrides everything else.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
`ifdef ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_d    = dec_ctrl;
                        illegal_d = (dec_ctrl == CTRL_ILL);
                        cnt_d     = '0;
                        if (dec_is_shift) begin
                            result_d = src_a;
                            if (shamt == '0) begin
                                zero_d  = (src_a == '0);
                                state_d = DONE;
                            end else begin
                                cnt_d   = {1'b0, shamt};
                                state_d = SHIFT;
                            end
`ifdef ALU_MUL_EN
                        end else if (dec_ctrl == CTRL_MUL) begin
                            result_d = '0;
                            mcand_d  = src_a;
                            mplier_d = src_b;
                            cnt_d    = CW'(XLEN);
                            state_d  = MUL;
`endif
                        end else begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            state_d  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    result_d = shift_step;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        zero_d  = (shift_step == '0);
                        state_d = DONE;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    result_d = mul_acc;
                    mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        zero_d  = (mul_acc == '0);
                        state_d = DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_mc_unit -- self-checking bench for alu_mc_unit (XLEN=32).
// Expected results come from a behavioural model, are queued when a request
// is driven and popped when the DUT presents its result.
// ---------------------------------------------------------------------------
module tb_alu_mc_unit;

    localparam int XLEN = 32;
`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [3:0]  ctrl;
        int          lat;
    } expT;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b0;
    logic        op5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [3:0]  alu_ctrl;

    int  checkCount = 0;
    int  passCount  = 0;
    expT expQ[$];

    alu_mc_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .op5(op5), .src_a(src_a), .src_b(src_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .alu_ctrl(alu_ctrl)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural reference for one operation.
    function automatic expT modelAlu(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                                     input logic f0, input logic o5,
                                     input logic [31:0] a, input logic [31:0] b);
        expT e;
        logic [4:0] sh;
        logic bad;
        sh = b[4:0];
        bad = 1'b0;
        e.res = '0; e.ctrl = 4'h0; e.lat = 1; e.ill = 1'b0;
        if (op == 2'b00) begin
            e.res = a + b; e.ctrl = 4'h0;
        end else if (op == 2'b01) begin
            e.res = a - b; e.ctrl = 4'h1;
        end else if (op == 2'b11) begin
            bad = 1'b1;
        end else if (o5 && f0) begin
            if (f3 == 3'b000 && MulEn) begin
                e.res = a * b; e.ctrl = 4'hA; e.lat = 33;
            end else bad = 1'b1;
        end else begin
            case (f3)
                3'd0: if (o5 && f5) begin e.res = a - b; e.ctrl = 4'h1; end
                      else begin e.res = a + b; e.ctrl = 4'h0; end
                3'd1: begin e.res = a << sh; e.ctrl = 4'h7; e.lat = int'(sh) + 1; end
                3'd2: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.ctrl = 4'h5; end
                3'd3: begin e.res = (a < b) ? 32'd1 : 32'd0; e.ctrl = 4'h6; end
                3'd4: begin e.res = a ^ b; e.ctrl = 4'h4; end
                3'd5: begin
                    if (f5) begin e.res = $unsigned($signed(a) >>> sh); e.ctrl = 4'h9; end
                    else begin e.res = a >> sh; e.ctrl = 4'h8; end
                    e.lat = int'(sh) + 1;
                end
                3'd6: begin e.res = a | b; e.ctrl = 4'h3; end
                default: begin e.res = a & b; e.ctrl = 4'h2; end
            endcase
        end
        if (bad) begin
            e.res = '0; e.ctrl = 4'hF; e.ill = 1'b1; e.lat = 1;
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Presents one request while IDLE; returns #1 after the accepting edge.
    task automatic driveReq(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                            input logic f0, input logic o5,
                            input logic [31:0] a, input logic [31:0] b);
        aluop = op; funct3 = f3; funct7b5 = f5; funct7b0 = f0; op5 = o5;
        src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                                 input logic f0, input logic o5,
                                 input logic [31:0] a, input logic [31:0] b);
        expQ.push_back(modelAlu(op, f3, f5, f0, o5, a, b));
        driveReq(op, f3, f5, f0, o5, a, b);
    endtask

    // Waits for the result, compares against the queue head, optionally
    // stalls the consumer for holdCycles, then hands the result off.
    task automatic collectResult(input string tag, input int holdCycles);
        int  cyc;
        expT e;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = expQ.pop_front();
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " result"},    64'(result),    64'(e.res));
        checkOutput({tag, " zero"},      64'(zero),      64'(e.zero));
        checkOutput({tag, " illegal"},   64'(illegal),   64'(e.ill));
        checkOutput({tag, " alu_ctrl"},  64'(alu_ctrl),  64'(e.ctrl));
        checkOutput({tag, " latency"},   64'(cyc),       64'(e.lat));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, " held valid"},  64'(out_valid), 64'd1);
            checkOutput({tag, " held result"}, 64'(result),    64'(e.res));
            checkOutput({tag, " held zero"},   64'(zero),      64'(e.zero));
            checkOutput({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        if (holdCycles > 0) checkOutput({tag, " in_ready at handoff"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " valid after handoff"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " ready after handoff"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        aluop = '0; funct3 = '0; funct7b5 = 1'b0; funct7b0 = 1'b0; op5 = 1'b0;
        src_a = '0; src_b = '0;

        // Asynchronous reset values, sampled before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result",    64'(result),    64'd0);
        checkOutput("reset zero",      64'(zero),      64'd0);
        checkOutput("reset illegal",   64'(illegal),   64'd0);
        checkOutput("reset alu_ctrl",  64'(alu_ctrl),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Decoded sub 5-7 accepted on the first edge after reset release.
        applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
        collectResult("sub5-7", 0);

        // Arithmetic shift by 4, then shift amount zero.
        applyStimulus(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
        collectResult("sra4", 0);
        applyStimulus(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0);
        collectResult("sra0", 0);
        applyStimulus(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'd31);
        collectResult("sll31", 0);

        // Multiply 7*6 (illegal when the multiplier is not built).
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7, 32'd6);
        collectResult("mul7x6", 0);

        // Boundaries: add wrap to zero, signed/unsigned compare, reserved aluop.
        applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        collectResult("addwrap", 0);
        applyStimulus(2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1);
        collectResult("slt", 0);
        applyStimulus(2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1);
        collectResult("sltu", 0);
        applyStimulus(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        collectResult("aluop11", 0);

        // Consumer stalls three cycles on a zero result.
        applyStimulus(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
        collectResult("sub9-9 stall", 3);

        // Reset in the third SHIFT cycle, then a fresh add.
        driveReq(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'd20);
        repeat (2) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midshift reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midshift reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("midshift reset result",    64'(result),    64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3);
        collectResult("add2+3", 0);

        // Flush a long operation while a new request is offered.
`ifdef ALU_MUL_EN
        driveReq(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7, 32'd6);
`else
        driveReq(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'd20);
`endif
        repeat (3) begin @(posedge clk); #1; end
        aluop = 2'b00; src_a = 32'd1; src_b = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush busy out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush busy in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        checkOutput("flush busy no result", 64'(out_valid), 64'd0);

        // Flush in IDLE blocks an accept in the same cycle.
        aluop = 2'b00; src_a = 32'd1; src_b = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush idle out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush idle in_ready",  64'(in_ready),  64'd1);

        // Flush in DONE discards the result.
        driveReq(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        checkOutput("flush done pre valid", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        checkOutput("flush done out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush done in_ready",  64'(in_ready),  64'd1);

        // Random operations.
        for (int n = 0; n < 24; n++) begin
            logic [1:0]  rop;
            logic [2:0]  rf3;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (n % 4 == 0) ? ra : $urandom;
            applyStimulus(rop, rf3, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), ra, rb);
            collectResult($sformatf("rand%0d", n), int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
